rijndael_sbox_scheduler: RTL and testbench
==========================================

// Module: rijndael_sbox_scheduler
// PURPOSE
//  Shares a bank of NUM_SBOX byte S-boxes between two requesters:
//  - the round datapath: SubBytes on a 128-bit state
//  - the key expansion: SubWord on a 32-bit word
//  Arbitrates non-preemptively (round-robin on ties) and sequences the state over 16/NUM_SBOX beats.
//  Returns registered results with a one-cycle valid pulse.
// PARAMETERS
//  NUM_SBOX  4  parallel S-boxes; legal values 4, 8, 16; BEATS = 16/NUM_SBOX
// PORTS
//  clk_i           in   1    clock, all state on rising edge
//  rst_i           in   1    synchronous reset, active-high
//  st_valid_i      in   1    state request valid
//  st_ready_o      out  1    state request accepted when valid&ready
//  st_data_i       in   128  state operand, byte i = [127-8i -: 8]
//  st_res_valid_o  out  1    one-cycle pulse: st_res_o updated
//  st_res_o        out  128  SubBytes(state), same byte order
//  kw_valid_i      in   1    key-word request valid
//  kw_ready_o      out  1    key-word request accepted when valid&ready
//  kw_data_i       in   32   word operand, byte j = [31-8j -: 8]
//  kw_res_valid_o  out  1    one-cycle pulse: kw_res_o updated
//  kw_res_o        out  32   SubWord(word), same byte order
//  busy_o          out  1    FSM not in IDLE
// BEHAVIOUR
//  - Reset: FSM=IDLE, beat counter=0, priority pointer favours ST.
//    All outputs 0 while rst_i high (ready gated low); res regs 0.
//  - FSM states: IDLE, ST_RUN, KW_RUN.
//    IDLE -> ST_RUN on ST accept; IDLE -> KW_RUN on KW accept.
//    ST_RUN -> IDLE after beat BEATS-1; KW_RUN -> IDLE after 1 cycle.
//  - Ready (combinational), only in IDLE and rst_i low:
//    st_ready_o = !kw_valid_i | prio==ST
//    kw_ready_o = !st_valid_i | prio==KW
//    At most one accept per cycle. Ready never depends on the requester's own valid.
//  - Priority pointer flips to the loser only when both valids are high in IDLE; otherwise it holds.
//  - Accept: operand latched into working register; no input needs to be held after the accept cycle.
//  - ST_RUN beat b (0..BEATS-1): S-box lane k gets byte b*NUM_SBOX+k.
//    Result is written to the working register at the same byte positions.
//    Counter wraps to 0 at the end of the job.
//  - KW_RUN: lanes 0..3 get word bytes 0..3; lanes >=4 are don't-care (driven 0).
//  - Latency (accept in cycle 0):
//    ST: run cycles 1..BEATS; st_res_o loaded and st_res_valid_o high in cycle BEATS+1.
//    KW: run cycle 1; kw_res_o loaded and kw_res_valid_o high in cycle 2.
//    The FSM is back in IDLE in the pulse cycle and may accept a new request in that same cycle.
//  - Throughput: back-to-back ST jobs, one every BEATS+1 cycles.
//  - st_res_o/kw_res_o change only at completion and hold their value until the next completion of the same kind.
//  - No result backpressure: consumers must take the pulse.
//  - rst_i mid-job: job aborted, no res_valid pulse, result regs cleared to 0.
//  - Valid dropped before accept: legal, nothing happens.
// STRUCTURE
//  - rijndael_pkg (shared):
//    BLOCK_BYTES=16, WORD_BYTES=4
//    typedefs byte_t, word_t (4 x byte_t), state_t (16 x byte_t)
//    enum sbox_sched_fsm_e {IDLE, ST_RUN, KW_RUN}
//  - Sub-module rijndael_sbox_bank #(NUM_SBOX): NUM_SBOX parallel existing byte S-boxes, packed lanes in/out, purely combinational.
//  - Arbiter, FSM, beat counter, lane mux and result write-back live in this module.
// TESTING
//  1. ST 00112233445566778899aabbccddeeff, NUM_SBOX=4
//     -> st_res_o 638293c31bfc33f5c4eeacea4bc12816
//     -> res_valid exactly in cycle 5 after accept; busy_o high cycles 1..4
//  2. KW cf4f3c09 -> kw_res_o 8a84eb01, kw_res_valid_o in cycle 2; st_res_o unchanged
//  3. Both valid in IDLE after reset -> ST accepted first.
//     KW accepted in ST completion cycle -> KW result 2 cycles later.
//     Tie repeated -> KW wins.
//  4. Back-to-back ST requests held valid -> accepts every BEATS+1 cycles.
//     Results alternate correctly for ff..ff (-> all 16) and 00..00 (-> all 63).
//  5. rst_i asserted in ST_RUN beat 2 -> no pulse, all outputs 0, ready high the cycle after rst_i drops.
//  6. Sweep NUM_SBOX=8,16 with test 1 -> pulse in cycles 3 and 2; results identical.

Source files
------------

// File: rtl/rijndael_pkg.sv
// Shared Rijndael types, sizes, scheduler FSM encoding and the byte S-box lookup.
package rijndael_pkg;

  localparam int unsigned BLOCK_BYTES = 16;
  localparam int unsigned WORD_BYTES  = 4;

  typedef logic [7:0] byte_t;
  typedef byte_t [WORD_BYTES-1:0]  word_t;
  typedef byte_t [BLOCK_BYTES-1:0] state_t;

  typedef enum logic [1:0] {IDLE, ST_RUN, KW_RUN} sbox_sched_fsm_e;

  // Forward S-box, entry 0x00 in the most significant byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic byte_t sbox(input byte_t x);
    return SBOX_TABLE[2047 - 8 * int'(x) -: 8];
  endfunction

endpackage

// File: rtl/rijndael_sbox_bank.sv
// NUM_SBOX parallel byte S-boxes; lane k occupies bits [8k +: 8] on both sides.
module rijndael_sbox_bank
  import rijndael_pkg::*;
#(
  parameter int unsigned NUM_SBOX = 4
) (
  input  logic [8*NUM_SBOX-1:0] lanes_i,
  output logic [8*NUM_SBOX-1:0] lanes_o
);

  // Substitute every lane independently.
  always_comb begin
    lanes_o = '0;
    for (int k = 0; k < NUM_SBOX; k++) begin
      lanes_o[8*k +: 8] = sbox(lanes_i[8*k +: 8]);
    end
  end

endmodule

// File: rtl/rijndael_sbox_scheduler.sv
// Shares one S-box bank between the SubBytes state path and the SubWord key path.
// Non-preemptive round-robin arbitration, state processed NUM_SBOX bytes per beat.
module rijndael_sbox_scheduler
  import rijndael_pkg::*;
#(
  parameter int unsigned NUM_SBOX = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         st_valid_i,
  output logic         st_ready_o,
  input  logic [127:0] st_data_i,
  output logic         st_res_valid_o,
  output logic [127:0] st_res_o,
  input  logic         kw_valid_i,
  output logic         kw_ready_o,
  input  logic [31:0]  kw_data_i,
  output logic         kw_res_valid_o,
  output logic [31:0]  kw_res_o,
  output logic         busy_o
);

  localparam int unsigned BEATS = BLOCK_BYTES / NUM_SBOX;
  localparam int unsigned CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);
  localparam logic PRIO_ST = 1'b0;
  localparam logic PRIO_KW = 1'b1;

  sbox_sched_fsm_e state_q, state_d;
  logic [CW-1:0]   beat_q, beat_d;
  logic            prio_q, prio_d;
  logic [127:0]    work_q, work_d;
  logic [127:0]    st_res_q, st_res_d;
  logic [31:0]     kw_res_q, kw_res_d;
  logic            st_pulse_q, st_pulse_d;
  logic            kw_pulse_q, kw_pulse_d;
  logic            st_rdy, kw_rdy;

  logic [8*NUM_SBOX-1:0] lane_in, lane_out;

  rijndael_sbox_bank #(
    .NUM_SBOX(NUM_SBOX)
  ) u_bank (
    .lanes_i(lane_in),
    .lanes_o(lane_out)
  );

  // Lane mux: state bytes of the current beat, or the key word in lanes 0..3.
  always_comb begin
    lane_in = '0;
    case (state_q)
      ST_RUN: begin
        for (int k = 0; k < NUM_SBOX; k++) begin
          lane_in[8*k +: 8] = work_q[127 - 8*(int'(beat_q)*NUM_SBOX + k) -: 8];
        end
      end
      KW_RUN: begin
        for (int k = 0; k < WORD_BYTES; k++) begin
          lane_in[8*k +: 8] = work_q[31 - 8*k -: 8];
        end
      end
      default: ;
    endcase
  end

  // Arbitration, FSM next state, beat counter and result write-back.
  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    prio_d     = prio_q;
    work_d     = work_q;
    st_res_d   = st_res_q;
    kw_res_d   = kw_res_q;
    st_pulse_d = 1'b0;
    kw_pulse_d = 1'b0;
    st_rdy     = 1'b0;
    kw_rdy     = 1'b0;
    case (state_q)
      IDLE: begin
        // Ready looks only at the other requester's valid and the pointer.
        st_rdy = !rst_i && (!kw_valid_i || prio_q == PRIO_ST);
        kw_rdy = !rst_i && (!st_valid_i || prio_q == PRIO_KW);
        if (st_valid_i && st_rdy) begin
          work_d  = st_data_i;
          beat_d  = '0;
          state_d = ST_RUN;
        end else if (kw_valid_i && kw_rdy) begin
          work_d  = {96'b0, kw_data_i};
          state_d = KW_RUN;
        end
        // On a tie the winner was prio_q, so hand priority to the loser.
        if (st_valid_i && kw_valid_i) begin
          prio_d = ~prio_q;
        end
      end
      ST_RUN: begin
        for (int k = 0; k < NUM_SBOX; k++) begin
          work_d[127 - 8*(int'(beat_q)*NUM_SBOX + k) -: 8] = lane_out[8*k +: 8];
        end
        if (beat_q == LAST_BEAT) begin
          beat_d     = '0;
          state_d    = IDLE;
          st_res_d   = work_d;
          st_pulse_d = 1'b1;
        end else begin
          beat_d = beat_q + CW'(1);
        end
      end
      KW_RUN: begin
        for (int k = 0; k < WORD_BYTES; k++) begin
          kw_res_d[31 - 8*k -: 8] = lane_out[8*k +: 8];
        end
        state_d    = IDLE;
        kw_pulse_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      beat_q     <= '0;
      prio_q     <= PRIO_ST;
      work_q     <= '0;
      st_res_q   <= '0;
      kw_res_q   <= '0;
      st_pulse_q <= 1'b0;
      kw_pulse_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      prio_q     <= prio_d;
      work_q     <= work_d;
      st_res_q   <= st_res_d;
      kw_res_q   <= kw_res_d;
      st_pulse_q <= st_pulse_d;
      kw_pulse_q <= kw_pulse_d;
    end
  end

  // Outputs forced to 0 for the whole time reset is held.
  always_comb begin
    st_ready_o     = st_rdy;
    kw_ready_o     = kw_rdy;
    busy_o         = !rst_i && (state_q != IDLE);
    st_res_valid_o = !rst_i && st_pulse_q;
    kw_res_valid_o = !rst_i && kw_pulse_q;
    st_res_o       = rst_i ? '0 : st_res_q;
    kw_res_o       = rst_i ? '0 : kw_res_q;
  end

endmodule

// File: tb/tb_rijndael_sbox_scheduler.sv
// Scoreboard bench: accepts push expected results, a monitor pops them on each result pulse.
module tb_rijndael_sbox_scheduler;

  localparam int NSB   = 4;
  localparam int BEATS = 16 / NSB;

  localparam logic [127:0] T1_IN  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] T1_OUT = 128'h638293c31bfc33f5c4eeacea4bc12816;
  localparam logic [127:0] ALL_FF = {16{8'hff}};
  localparam logic [127:0] ALL_16 = {16{8'h16}};
  localparam logic [127:0] ALL_00 = '0;
  localparam logic [127:0] ALL_63 = {16{8'h63}};

  logic         clk = 1'b0;
  logic         rst;
  logic         st_valid, st_ready, st_res_valid;
  logic [127:0] st_data, st_res;
  logic         kw_valid, kw_ready, kw_res_valid;
  logic [31:0]  kw_data, kw_res;
  logic         busy;

  logic [127:0] st_exp;
  logic [31:0]  kw_exp;

  typedef struct {
    logic [127:0] data;
    int           cyc;
  } exp_t;

  exp_t st_q[$];
  exp_t kw_q[$];

  int cyc = 0;
  int total = 0;
  int bad = 0;
  int st_acc_cnt = 0, kw_acc_cnt = 0;
  int st_acc_cyc = 0, kw_acc_cyc = 0;

  rijndael_sbox_scheduler #(
    .NUM_SBOX(NSB)
  ) u_dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .st_valid_i    (st_valid),
    .st_ready_o    (st_ready),
    .st_data_i     (st_data),
    .st_res_valid_o(st_res_valid),
    .st_res_o      (st_res),
    .kw_valid_i    (kw_valid),
    .kw_ready_o    (kw_ready),
    .kw_data_i     (kw_data),
    .kw_res_valid_o(kw_res_valid),
    .kw_res_o      (kw_res),
    .busy_o        (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, exp);
    end
  endtask

  // Record accepts: the request is taken at the next rising edge.
  always @(negedge clk) begin
    #1;
    if (rst === 1'b0 && st_valid && st_ready) begin
      st_q.push_back('{data: st_exp, cyc: cyc + BEATS + 1});
      st_acc_cyc = cyc;
      st_acc_cnt++;
    end
    if (rst === 1'b0 && kw_valid && kw_ready) begin
      kw_q.push_back('{data: {96'b0, kw_exp}, cyc: cyc + 2});
      kw_acc_cyc = cyc;
      kw_acc_cnt++;
    end
  end

  // Monitor: every result pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (st_res_valid === 1'b1) begin
      if (st_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL st_unexpected_pulse: got pulse at cycle %0d want none", cyc);
      end else begin
        e = st_q.pop_front();
        check("st_res", st_res, e.data);
        check("st_latency", 128'(cyc), 128'(e.cyc));
      end
    end
    if (kw_res_valid === 1'b1) begin
      if (kw_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL kw_unexpected_pulse: got pulse at cycle %0d want none", cyc);
      end else begin
        e = kw_q.pop_front();
        check("kw_res", {96'b0, kw_res}, e.data);
        check("kw_latency", 128'(cyc), 128'(e.cyc));
      end
    end
  end

  // Bounded wait for an accept; call right after driving at a falling edge.
  task automatic wait_acc(input bit is_kw, input int n0, input string name);
    int k = 0;
    #2;
    while ((is_kw ? kw_acc_cnt : st_acc_cnt) == n0 && k < 100) begin
      @(negedge clk);
      #2;
      k++;
    end
    total++;
    if ((is_kw ? kw_acc_cnt : st_acc_cnt) == n0) begin
      bad++;
      $display("FAIL %s: got no accept want accept within 100 cycles", name);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, k0, c0;
    rst      = 1'b1;
    st_valid = 1'b1;
    kw_valid = 1'b0;
    st_data  = '0;
    kw_data  = '0;
    st_exp   = '0;
    kw_exp   = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_st_ready", 128'(st_ready), 128'(0));
    check("rst_kw_ready", 128'(kw_ready), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_st_res", st_res, '0);
    check("rst_kw_res", 128'(kw_res), '0);
    @(negedge clk);
    rst      = 1'b0;
    st_valid = 1'b0;

    // Test 1: single state job and busy window.
    n0 = st_acc_cnt;
    @(negedge clk);
    st_valid = 1'b1; st_data = T1_IN; st_exp = T1_OUT;
    wait_acc(1'b0, n0, "t1_accept");
    for (int i = 1; i <= BEATS + 1; i++) begin
      @(negedge clk);
      if (i == 1) st_valid = 1'b0;
      #3;
      check($sformatf("t1_busy_c%0d", i), 128'(busy), 128'(i <= BEATS));
    end

    // Test 2: key word, state result must hold.
    n0 = kw_acc_cnt;
    @(negedge clk);
    kw_valid = 1'b1; kw_data = 32'hcf4f3c09; kw_exp = 32'h8a84eb01;
    wait_acc(1'b1, n0, "t2_accept");
    @(negedge clk);
    kw_valid = 1'b0;
    repeat (2) @(negedge clk);
    #3;
    check("t2_st_res_hold", st_res, T1_OUT);

    // Test 3: tie after reset goes to ST, KW takes the completion cycle, next tie goes to KW.
    n0 = st_acc_cnt; k0 = kw_acc_cnt;
    @(negedge clk);
    st_valid = 1'b1; st_data = ALL_FF; st_exp = ALL_16;
    kw_valid = 1'b1; kw_data = 32'h0;  kw_exp = 32'h63636363;
    wait_acc(1'b0, n0, "t3_st_accept");
    check("t3_kw_waits", 128'(kw_acc_cnt), 128'(k0));
    @(negedge clk);
    st_valid = 1'b0;
    wait_acc(1'b1, k0, "t3_kw_accept");
    check("t3_kw_acc_cycle", 128'(kw_acc_cyc), 128'(st_acc_cyc + BEATS + 1));
    @(negedge clk);
    kw_valid = 1'b0;
    repeat (3) @(negedge clk);
    n0 = st_acc_cnt; k0 = kw_acc_cnt;
    st_valid = 1'b1; st_data = ALL_00; st_exp = ALL_63;
    kw_valid = 1'b1; kw_data = 32'hffffffff; kw_exp = 32'h16161616;
    wait_acc(1'b1, k0, "t3_tie2_kw_accept");
    check("t3_tie2_st_waits", 128'(st_acc_cnt), 128'(n0));
    @(negedge clk);
    kw_valid = 1'b0;
    wait_acc(1'b0, n0, "t3_tie2_st_accept");
    check("t3_tie2_st_acc_cycle", 128'(st_acc_cyc), 128'(kw_acc_cyc + 2));
    @(negedge clk);
    st_valid = 1'b0;
    repeat (BEATS + 3) @(negedge clk);

    // Test 4: back-to-back state jobs with valid held high.
    n0 = st_acc_cnt;
    st_valid = 1'b1; st_data = ALL_FF; st_exp = ALL_16;
    wait_acc(1'b0, n0, "t4_accept0");
    c0 = st_acc_cyc;
    for (int j = 1; j <= 2; j++) begin
      n0 = st_acc_cnt;
      @(negedge clk);
      st_data = (j == 1) ? ALL_00 : ALL_FF;
      st_exp  = (j == 1) ? ALL_63 : ALL_16;
      wait_acc(1'b0, n0, $sformatf("t4_accept%0d", j));
      check($sformatf("t4_interval%0d", j), 128'(st_acc_cyc - c0), 128'(BEATS + 1));
      c0 = st_acc_cyc;
    end
    @(negedge clk);
    st_valid = 1'b0;
    repeat (BEATS + 3) @(negedge clk);

    // Test 5: reset during beat 2 aborts the job.
    n0 = st_acc_cnt;
    st_valid = 1'b1; st_data = T1_IN; st_exp = T1_OUT;
    wait_acc(1'b0, n0, "t5_accept");
    @(negedge clk);
    st_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    st_q.delete();
    #1;
    check("t5_rst_busy", 128'(busy), 128'(0));
    check("t5_rst_st_res", st_res, '0);
    check("t5_rst_kw_res", 128'(kw_res), '0);
    check("t5_rst_st_ready", 128'(st_ready), 128'(0));
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("t5_ready_after", 128'(st_ready), 128'(1));
    check("t5_busy_after", 128'(busy), 128'(0));
    check("t5_st_res_cleared", st_res, '0);
    check("t5_kw_res_cleared", 128'(kw_res), '0);
    repeat (BEATS + 4) @(negedge clk);

    repeat (10) @(negedge clk);
    check("st_queue_drained", 128'(st_q.size()), 128'(0));
    check("kw_queue_drained", 128'(kw_q.size()), 128'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Test 6: wider banks, one state job each.
  for (genvar g = 0; g < 2; g++) begin : g_sweep
    localparam int N = 8 << g;
    localparam int B = 16 / N;
    logic         sv, sr, srv, kr, krv, bz;
    logic [127:0] sres;
    logic [31:0]  kres;

    rijndael_sbox_scheduler #(
      .NUM_SBOX(N)
    ) u_dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .st_valid_i    (sv),
      .st_ready_o    (sr),
      .st_data_i     (T1_IN),
      .st_res_valid_o(srv),
      .st_res_o      (sres),
      .kw_valid_i    (1'b0),
      .kw_ready_o    (kr),
      .kw_data_i     (32'h0),
      .kw_res_valid_o(krv),
      .kw_res_o      (kres),
      .busy_o        (bz)
    );

    initial begin
      int c;
      int k;
      sv = 1'b0;
      wait (rst === 1'b0);
      @(negedge clk);
      sv = 1'b1;
      #1;
      c = cyc;
      check($sformatf("sweep%0d_ready", N), 128'(sr), 128'(1));
      @(negedge clk);
      sv = 1'b0;
      k = 0;
      #2;
      while (srv !== 1'b1 && k < 40) begin
        @(negedge clk);
        #2;
        k++;
      end
      check($sformatf("sweep%0d_latency", N), 128'(cyc), 128'(c + B + 1));
      check($sformatf("sweep%0d_res", N), sres, T1_OUT);
    end
  end

endmodule
